// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   VGA raster timing generator. Divides CLK down to a pixel-clock enable,
//   runs horizontal (h) and vertical (v) counters over the full frame,
//   including blanking, and drives the coordinates, active-area flags and
//   active-low sync pulses.
//
// Ports
//   CLK          in   system clock, rising edge
//   RST          in   synchronous reset, active-low
//   pix_ce       out  pixel clock enable, high one CLK in every CLK_DIV
//   row  [9:0]   out  horizontal pixel counter h (X coordinate)
//   col  [9:0]   out  vertical line counter v (Y coordinate)
//   hnotactive   out  h >= H_ACTIVE
//   vnotactive   out  v >= V_ACTIVE
//   hsync        out  active-low horizontal sync
//   vsync        out  active-low vertical sync
//   frame_start  out  one-CLK pulse when (row,col) becomes (0,0), and after reset
//   frame_cnt    out  frame counter, built only when VGA_FRAME_CNT_EN is
//                     defined; otherwise tied to 0
//
// All outputs are registered and derived from the counters' next values, so
// flags and syncs always match the row/col presented in the same cycle.

module vga_sync_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned CLK_DIV  = 2
) (
   input  logic       CLK,
   input  logic       RST,
   output logic       pix_ce,
   output logic [9:0] row,
   output logic [9:0] col,
   output logic       hnotactive,
   output logic       vnotactive,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_start,
   output logic [7:0] frame_cnt
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
   end
   if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_sync_gen: CLK_DIV must be in 1..16");
   end

   // 11-bit thresholds so a boundary equal to 1024 does not wrap to 0.
   localparam logic [10:0] H_ACT_L  = 11'(H_ACTIVE);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] V_ACT_L  = 11'(V_ACTIVE);
   localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);

   logic [3:0] div_q, div_d;
   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;
   logic       pix_ce_q, pix_ce_d;
   logic       hna_q, hna_d;
   logic       vna_q, vna_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       fs_q, fs_d;
   logic       rst_seen_q;
   logic       frame_wrap;

   always_comb begin
      h_d        = h_q;
      v_d        = v_q;
      frame_wrap = 1'b0;

      div_d = (div_q == DIV_LAST) ? '0 : div_q + 4'd1;

      if (pix_ce_q) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
               v_d        = '0;
               frame_wrap = 1'b1;
            end else begin
               v_d = v_q + 10'd1;
            end
         end else begin
            h_d = h_q + 10'd1;
         end
      end

      pix_ce_d = (div_d == DIV_LAST);
      hna_d    = ({1'b0, h_d} >= H_ACT_L);
      vna_d    = ({1'b0, v_d} >= V_ACT_L);
      hsync_d  = !(({1'b0, h_d} >= HS_START) && ({1'b0, h_d} < HS_END));
      vsync_d  = !(({1'b0, v_d} >= VS_START) && ({1'b0, v_d} < VS_END));
      // rst_seen_q marks the first edge after release for the extra pulse.
      fs_d     = frame_wrap | rst_seen_q;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         div_q      <= '0;
         h_q        <= '0;
         v_q        <= '0;
         pix_ce_q   <= (DIV_LAST == 4'd0);
         hna_q      <= 1'b0;
         vna_q      <= 1'b0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         fs_q       <= 1'b0;
         rst_seen_q <= 1'b1;
      end else begin
         div_q      <= div_d;
         h_q        <= h_d;
         v_q        <= v_d;
         pix_ce_q   <= pix_ce_d;
         hna_q      <= hna_d;
         vna_q      <= vna_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         fs_q       <= fs_d;
         rst_seen_q <= 1'b0;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [7:0] frame_cnt_q, frame_cnt_d;

   // Counts wraps only; the post-reset frame_start pulse is not a new frame.
   always_comb begin
      frame_cnt_d = frame_cnt_q + 8'(frame_wrap);
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         frame_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = '0;
`endif

   assign pix_ce      = pix_ce_q;
   assign row         = h_q;
   assign col         = v_q;
   assign hnotactive  = hna_q;
   assign vnotactive  = vna_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign frame_start = fs_q;

endmodule
